// File: rtl/sid_wr_sched.sv
// sid_wr_sched: schedules register writes into the sid8580 register port.
//
// Two sources share the port: the 6510 CPU bus (highest priority, one-entry
// holding register) and a tune-player / loader stream buffered in a FIFO. At
// most one write is issued per 1 MHz slot (ce_1m), so SID register timing
// matches the real bus. A starvation counter forces one player grant after
// STARVE_LIM consecutive CPU grants while the FIFO holds data.
//
// Optional build macro: SID_SHADOW_EN -- adds a 25x8 shadow RAM of every issued
// write (the SID registers are write-only), read back on shadow_addr/shadow_data
// with one cycle of latency. Without it shadow_data is tied to 8'h00.
//
// Ports:
//   clk, reset        system clock; asynchronous active-high reset
//   ce_1m             1 MHz slot enable, one clk wide
//   cpu_we/addr/data  CPU write strobe, register address (also read path), data
//   cpu_overrun       sticky: a pending CPU write was overwritten
//   ply_en            player enable; 0 flushes the FIFO
//   ply_valid/addr/data, ply_ready   player push handshake
//   fifo_level        FIFO occupancy (0 .. 2^FIFO_AW)
//   sid_we/addr/data  register port towards the SID core
//   shadow_addr/data  shadow readback (optional feature)

module sid_wr_sched #(
  parameter int FIFO_AW    = 4,
  parameter int STARVE_LIM = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce_1m,
  input  logic             cpu_we,
  input  logic [4:0]       cpu_addr,
  input  logic [7:0]       cpu_data,
  output logic             cpu_overrun,
  input  logic             ply_en,
  input  logic             ply_valid,
  input  logic [4:0]       ply_addr,
  input  logic [7:0]       ply_data,
  output logic             ply_ready,
  output logic [FIFO_AW:0] fifo_level,
  output logic             sid_we,
  output logic [4:0]       sid_addr,
  output logic [7:0]       sid_data,
  input  logic [4:0]       shadow_addr,
  output logic [7:0]       shadow_data
);

  localparam int               DEPTH      = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_LVL   = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0] PTR_ONE    = (FIFO_AW + 1)'(1);
  localparam logic [7:0]       STARVE_MAX = 8'(STARVE_LIM);
  localparam logic [4:0]       LAST_REG   = 5'h18;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_CPU,
    SRC_PLY
  } src_e;

  typedef struct packed {
    logic [4:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t              cpu_hold;
  logic             cpu_pend;
  wr_t              fifo_mem [DEPTH];
  // One extra pointer bit separates full from empty when the indices match.
  logic [FIFO_AW:0] wr_ptr;
  logic [FIFO_AW:0] rd_ptr;
  logic [7:0]       starve_cnt;
  logic [4:0]       sid_addr_w;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             store;
  wr_t              fifo_head;
  wr_t              granted;
  src_e             grant;

  assign fifo_level = wr_ptr - rd_ptr;
  assign fifo_empty = (fifo_level == '0);
  assign fifo_full  = (fifo_level == FULL_LVL);
  assign ply_ready  = ~reset & ply_en & ~fifo_full;
  assign push       = ply_valid & ply_ready;
  // Out-of-range player addresses complete the handshake but are dropped.
  assign store      = push & (ply_addr <= LAST_REG);
  assign fifo_head  = fifo_mem[rd_ptr[FIFO_AW-1:0]];

  // Grant looks only at registered state, so a cpu_we or push arriving in
  // the slot cycle itself waits for the next slot.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    grant = SRC_NONE;
    if (ce_1m) begin
      if (!fifo_empty && (!cpu_pend || starve_cnt == STARVE_MAX)) begin
        grant = SRC_PLY;
      end else if (cpu_pend) begin
        grant = SRC_CPU;
      end
    end
  end

  assign granted  = (grant == SRC_CPU) ? cpu_hold : fifo_head;
  assign sid_addr = sid_we ? sid_addr_w : cpu_addr;

  // CPU holding register. A write landing on the grant edge of the current
  // entry simply becomes the next pending entry.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every block sees
    // the pre-edge values regardless of evaluation order.
    if (reset) begin
      cpu_pend    <= 1'b0;
      cpu_hold    <= '0;
      cpu_overrun <= 1'b0;
    end else if (cpu_we) begin
      cpu_hold <= '{addr: cpu_addr, data: cpu_data};
      cpu_pend <= 1'b1;
      if (cpu_pend && grant != SRC_CPU) begin
        cpu_overrun <= 1'b1;
      end
    end else if (grant == SRC_CPU) begin
      cpu_pend <= 1'b0;
    end
  end

  // FIFO pointers; a flush wins over a pop taken at the same edge, but that
  // pop's data is still issued below.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (store) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (!ply_en) begin
        rd_ptr <= wr_ptr;
      end else if (grant == SRC_PLY) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // NOTE: storage array is deliberately not reset; the pointers alone define
  // which entries are valid, and an unreset array maps onto RAM.
  always_ff @(posedge clk) begin
    if (store) begin
      fifo_mem[wr_ptr[FIFO_AW-1:0]] <= '{addr: ply_addr, data: ply_data};
    end
  end

  // Counts CPU grants taken while the player is waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (grant == SRC_PLY || fifo_empty) begin
      starve_cnt <= '0;
    end else if (grant == SRC_CPU) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

  // Issue register: one-clk write strobe after each grant edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sid_we     <= 1'b0;
      sid_addr_w <= '0;
      sid_data   <= '0;
    end else begin
      sid_we <= (grant != SRC_NONE);
      if (grant != SRC_NONE) begin
        sid_addr_w <= granted.addr;
        sid_data   <= granted.data;
      end
    end
  end

`ifdef SID_SHADOW_EN
  logic [7:0] shadow_mem [25];

  // Recorded at the grant edge, so a readback issued in the following cycle
  // already sees the new value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 25; i++) begin
        shadow_mem[i] <= '0;
      end
      shadow_data <= '0;
    end else begin
      if (grant != SRC_NONE && granted.addr <= LAST_REG) begin
        shadow_mem[granted.addr] <= granted.data;
      end
      shadow_data <= (shadow_addr <= LAST_REG) ? shadow_mem[shadow_addr] : 8'h00;
    end
  end
`else
  logic shadow_addr_unused;
  assign shadow_addr_unused = ^shadow_addr;
  assign shadow_data        = 8'h00;
`endif

endmodule

// File: tb/tb_sid_wr_sched.sv
// Testbench for sid_wr_sched (FIFO_AW=2, STARVE_LIM=8). A reference model of
// the scheduler predicts each grant; predicted writes go into a queue that is
// compared against sid_we/sid_addr/sid_data after every clock edge.
module tb_sid_wr_sched;

  localparam int FIFO_AW    = 2;
  localparam int DEPTH      = 1 << FIFO_AW;
  localparam int STARVE_LIM = 8;

  typedef struct packed {
    logic [4:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    logic       cwe;
    logic [4:0] ca;
    logic [7:0] cd;
    logic       ce;
    logic       pv;
    logic [4:0] pa;
    logic [7:0] pd;
    logic       pen;
    int         exp_level;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             ce_1m = 1'b0;
  logic             cpu_we = 1'b0;
  logic [4:0]       cpu_addr = '0;
  logic [7:0]       cpu_data = '0;
  logic             cpu_overrun;
  logic             ply_en = 1'b1;
  logic             ply_valid = 1'b0;
  logic [4:0]       ply_addr = '0;
  logic [7:0]       ply_data = '0;
  logic             ply_ready;
  logic [FIFO_AW:0] fifo_level;
  logic             sid_we;
  logic [4:0]       sid_addr;
  logic [7:0]       sid_data;
  logic [4:0]       shadow_addr = '0;
  logic [7:0]       shadow_data;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state and scoreboard.
  wr_t  exp_q [$];
  wr_t  m_fifo [$];
  wr_t  m_hold;
  logic m_pend;
  logic m_ovr;
  int   m_starve;

  vec_t vecs [16];

  sid_wr_sched #(.FIFO_AW(FIFO_AW), .STARVE_LIM(STARVE_LIM)) dut (
    .clk(clk), .reset(reset), .ce_1m(ce_1m),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_overrun(cpu_overrun),
    .ply_en(ply_en), .ply_valid(ply_valid), .ply_addr(ply_addr),
    .ply_data(ply_data), .ply_ready(ply_ready), .fifo_level(fifo_level),
    .sid_we(sid_we), .sid_addr(sid_addr), .sid_data(sid_data),
    .shadow_addr(shadow_addr), .shadow_data(shadow_data)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one edge and compare the issue port against the scoreboard.
  task automatic tick();
    logic exp_we;
    wr_t  e;
    @(posedge clk);
    #1;
    exp_we = (exp_q.size() != 0);
    check("sid_we", 32'(sid_we), 32'(exp_we));
    if (exp_we) begin
      e = exp_q.pop_front();
      if (sid_we) begin
        check("sid_addr", 32'(sid_addr), 32'(e.addr));
        check("sid_data", 32'(sid_data), 32'(e.data));
      end
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_fifo.delete();
    m_hold   = '0;
    m_pend   = 1'b0;
    m_ovr    = 1'b0;
    m_starve = 0;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    ce_1m     = 1'b0;
    cpu_we    = 1'b0;
    ply_valid = 1'b0;
    ply_en    = 1'b1;
    @(posedge clk);
    #1;
    check("rst_sid_we", 32'(sid_we), 32'(0));
    check("rst_sid_data", 32'(sid_data), 32'(0));
    check("rst_level", 32'(fifo_level), 32'(0));
    check("rst_ply_ready", 32'(ply_ready), 32'(0));
    check("rst_overrun", 32'(cpu_overrun), 32'(0));
    check("rst_shadow", 32'(shadow_data), 32'(0));
    reset = 1'b0;
    model_clear();
  endtask

  // One clock of stimulus; the model decides the grant from pre-edge state.
  task automatic step(input logic cwe, input logic [4:0] ca, input logic [7:0] cd,
                      input logic ce, input logic pv, input logic [4:0] pa,
                      input logic [7:0] pd, input logic pen);
    logic exp_ready;
    logic gply;
    logic gcpu;
    cpu_we = cwe; cpu_addr = ca; cpu_data = cd; ce_1m = ce;
    ply_valid = pv; ply_addr = pa; ply_data = pd; ply_en = pen;
    #1;
    exp_ready = pen && (m_fifo.size() < DEPTH);
    check("ply_ready", 32'(ply_ready), 32'(exp_ready));
    if (!sid_we) check("sid_addr_read", 32'(sid_addr), 32'(ca));
    gply = ce && (m_fifo.size() != 0) && (!m_pend || m_starve == STARVE_LIM);
    gcpu = ce && m_pend && !gply;
    if (gcpu) exp_q.push_back(m_hold);
    if (gply) exp_q.push_back(m_fifo[0]);
    if (gply || m_fifo.size() == 0) m_starve = 0;
    else if (gcpu) m_starve++;
    if (cwe) begin
      if (m_pend && !gcpu) m_ovr = 1'b1;
      m_hold = '{addr: ca, data: cd};
      m_pend = 1'b1;
    end else if (gcpu) begin
      m_pend = 1'b0;
    end
    if (gply) void'(m_fifo.pop_front());
    if (!pen) m_fifo.delete();
    else if (pv && exp_ready && pa <= 5'h18) m_fifo.push_back('{addr: pa, data: pd});
    tick();
    cpu_we = 1'b0; ce_1m = 1'b0; ply_valid = 1'b0;
    check("fifo_level", 32'(fifo_level), 32'(m_fifo.size()));
    check("cpu_overrun", 32'(cpu_overrun), 32'(m_ovr));
  endtask

  task automatic idle();
    step(1'b0, 5'h0A, 8'h00, 1'b0, 1'b0, 5'h00, 8'h00, 1'b1);
  endtask

  task automatic slot();
    step(1'b0, 5'h0A, 8'h00, 1'b1, 1'b0, 5'h00, 8'h00, 1'b1);
  endtask

  initial begin
    logic [7:0] sh_exp;
`ifdef SID_SHADOW_EN
    sh_exp = 8'h1C;
`else
    sh_exp = 8'h00;
`endif

    //        cwe   ca     cd     ce    pv    pa     pd     pen  level
    vecs[0]  = '{1'b0, 5'h07, 8'h00, 1'b0, 1'b1, 5'h01, 8'h11, 1'b1, 1};
    vecs[1]  = '{1'b0, 5'h07, 8'h00, 1'b0, 1'b1, 5'h02, 8'h22, 1'b1, 2};
    vecs[2]  = '{1'b0, 5'h07, 8'h00, 1'b0, 1'b1, 5'h1B, 8'h33, 1'b1, 2};
    vecs[3]  = '{1'b1, 5'h0B, 8'h44, 1'b0, 1'b0, 5'h00, 8'h00, 1'b1, 2};
    vecs[4]  = '{1'b0, 5'h0A, 8'h00, 1'b1, 1'b0, 5'h00, 8'h00, 1'b1, 2};
    vecs[5]  = '{1'b0, 5'h0A, 8'h00, 1'b1, 1'b0, 5'h00, 8'h00, 1'b1, 1};
    vecs[6]  = '{1'b0, 5'h0A, 8'h00, 1'b1, 1'b1, 5'h03, 8'h33, 1'b1, 1};
    vecs[7]  = '{1'b1, 5'h0C, 8'h55, 1'b1, 1'b0, 5'h00, 8'h00, 1'b1, 0};
    vecs[8]  = '{1'b0, 5'h0A, 8'h00, 1'b1, 1'b0, 5'h00, 8'h00, 1'b1, 0};
    vecs[9]  = '{1'b0, 5'h0A, 8'h00, 1'b1, 1'b0, 5'h00, 8'h00, 1'b1, 0};
    vecs[10] = '{1'b0, 5'h0A, 8'h00, 1'b0, 1'b1, 5'h04, 8'h44, 1'b1, 1};
    vecs[11] = '{1'b0, 5'h0A, 8'h00, 1'b0, 1'b1, 5'h05, 8'h55, 1'b1, 2};
    vecs[12] = '{1'b0, 5'h0A, 8'h00, 1'b0, 1'b1, 5'h06, 8'h66, 1'b1, 3};
    vecs[13] = '{1'b0, 5'h0A, 8'h00, 1'b1, 1'b0, 5'h00, 8'h00, 1'b0, 0};
    vecs[14] = '{1'b0, 5'h0A, 8'h00, 1'b0, 1'b1, 5'h07, 8'h77, 1'b0, 0};
    vecs[15] = '{1'b0, 5'h0A, 8'h00, 1'b1, 1'b0, 5'h00, 8'h00, 1'b1, 0};

    model_clear();
    do_reset();

    // Table: mixed CPU/player traffic, discard, push+pop, flush with grant.
    for (int i = 0; i < 16; i++) begin
      step(vecs[i].cwe, vecs[i].ca, vecs[i].cd, vecs[i].ce,
           vecs[i].pv, vecs[i].pa, vecs[i].pd, vecs[i].pen);
      check($sformatf("vec%0d_level", i), 32'(fifo_level), 32'(vecs[i].exp_level));
    end

    // CPU write at cycle 3, slot at cycle 10: strobe only in cycle 11.
    do_reset();
    repeat (3) idle();
    step(1'b1, 5'h18, 8'h0F, 1'b0, 1'b0, 5'h00, 8'h00, 1'b1);
    repeat (6) idle();
    slot();
    check("t1_we_high", 32'(sid_we), 32'(1));
    idle();
    check("t1_we_low", 32'(sid_we), 32'(0));
    slot();

    // Overwrite of a pending CPU write.
    do_reset();
    step(1'b1, 5'h04, 8'h41, 1'b0, 1'b0, 5'h00, 8'h00, 1'b1);
    step(1'b1, 5'h04, 8'h40, 1'b0, 1'b0, 5'h00, 8'h00, 1'b1);
    check("ovr_set", 32'(cpu_overrun), 32'(1));
    slot();
    slot();
    repeat (3) idle();
    check("ovr_sticky", 32'(cpu_overrun), 32'(1));

    // cpu_we on the grant edge of the current entry: queued, no overrun.
    do_reset();
    step(1'b1, 5'h05, 8'h11, 1'b0, 1'b0, 5'h00, 8'h00, 1'b1);
    step(1'b1, 5'h05, 8'h22, 1'b1, 1'b0, 5'h00, 8'h00, 1'b1);
    check("coinc_no_ovr", 32'(cpu_overrun), 32'(0));
    slot();

    // Full FIFO: ply_valid held for five entries, four accepted.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 5'h0A, 8'h00, 1'b0, 1'b1, 5'(i + 1), 8'(8'hA0 + i), 1'b1);
    end
    check("full_level", 32'(fifo_level), 32'(4));
    check("full_ready", 32'(ply_ready), 32'(0));
    repeat (4) slot();
    check("drain_level", 32'(fifo_level), 32'(0));
    check("drain_ready", 32'(ply_ready), 32'(1));

    // Starvation: CPU pending each slot with the FIFO non-empty.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 5'h0A, 8'h00, 1'b0, 1'b1, 5'(5'h10 + i), 8'(8'hB0 + i), 1'b1);
    end
    for (int s = 0; s < 20; s++) begin
      step(1'b1, 5'h01, 8'(s), 1'b0, 1'b0, 5'h00, 8'h00, 1'b1);
      slot();
    end
    check("starve_level", 32'(fifo_level), 32'(1));

    // Discarded address and pure flush.
    do_reset();
    step(1'b0, 5'h0A, 8'h00, 1'b0, 1'b1, 5'h1B, 8'h99, 1'b1);
    check("discard_level", 32'(fifo_level), 32'(0));
    repeat (2) slot();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 5'h0A, 8'h00, 1'b0, 1'b1, 5'(5'h08 + i), 8'(8'hC0 + i), 1'b1);
    end
    check("pre_flush_level", 32'(fifo_level), 32'(3));
    step(1'b0, 5'h0A, 8'h00, 1'b0, 1'b0, 5'h00, 8'h00, 1'b0);
    check("flush_level", 32'(fifo_level), 32'(0));
    repeat (3) slot();

    // Shadow readback, then asynchronous reset during an issue.
    do_reset();
    step(1'b1, 5'h01, 8'h1C, 1'b0, 1'b0, 5'h00, 8'h00, 1'b1);
    slot();
    shadow_addr = 5'h01;
    idle();
    check("shadow_rd", 32'(shadow_data), 32'(sh_exp));
    shadow_addr = 5'h1D;
    idle();
    check("shadow_oob", 32'(shadow_data), 32'(0));
    step(1'b1, 5'h02, 8'h33, 1'b0, 1'b0, 5'h00, 8'h00, 1'b1);
    ce_1m = 1'b1;
    @(posedge clk);
    #1;
    ce_1m = 1'b0;
    check("mid_we", 32'(sid_we), 32'(1));
    check("mid_addr", 32'(sid_addr), 32'(5'h02));
    reset = 1'b1;
    #1;
    check("async_we", 32'(sid_we), 32'(0));
    check("async_data", 32'(sid_data), 32'(0));
    shadow_addr = 5'h01;
    do_reset();
    idle();
    check("shadow_cleared", 32'(shadow_data), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sid_wr_sched.md
Name: sid_wr_sched

Overview:
- Schedules register writes into the SID core (sid8580 register port: we/addr/data_in).
- Two write sources share that port:
  - the 6510 CPU bus, highest priority, single-entry holding register;
  - a tune-player / loader stream, buffered in a FIFO.
- Issues at most one SID write per 1 MHz slot (ce_1m), so SID register timing matches the real bus.
- Sits between the C64 bus decode / player logic and the sid8580 instance.

Parameters:
- FIFO_AW, 4: player FIFO address width; depth = 2^FIFO_AW entries.
- STARVE_LIM, 8: consecutive CPU grants allowed while the FIFO is non-empty before one player grant is forced (1..255).

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- ce_1m  in  1  1 MHz slot enable, one clk wide.
- cpu_we  in  1  CPU write strobe, one clk wide.
- cpu_addr  in  5  CPU register address; also drives reads.
- cpu_data  in  8  CPU write data.
- cpu_overrun  out  1  sticky: a CPU write overwrote a still-pending CPU write.
- ply_en  in  1  player enable; 0 flushes the FIFO.
- ply_valid  in  1  player write request.
- ply_addr  in  5  player register address.
- ply_data  in  8  player write data.
- ply_ready  out  1  FIFO accepts an entry this cycle.
- fifo_level  out  FIFO_AW+1  current FIFO occupancy.
- sid_we  out  1  write strobe to the SID core.
- sid_addr  out  5  address to the SID core.
- sid_data  out  8  write data to the SID core.
- shadow_addr  in  5  shadow readback address (optional feature).
- shadow_data  out  8  shadow readback data (optional feature).

Behaviour:
- Reset (async) clears:
  - CPU pending flag, FIFO pointers, starve counter, cpu_overrun;
  - sid_we=0, sid_data=0, shadow RAM.
- Reset outputs: fifo_level=0, ply_ready=0 while reset is asserted.
- CPU capture:
  - cpu_we at edge t loads {cpu_addr, cpu_data} into the holding register and sets pending.
  - If pending is already set and that entry is not issued at the same edge, the old entry is overwritten and cpu_overrun is set.
  - cpu_overrun clears only on reset.
- Player push:
  - ply_ready = ply_en & ~full.
  - An entry is pushed on ply_valid & ply_ready.
  - ply_addr > 5'h18 is accepted but discarded (not stored, level unchanged).
- Grant: evaluated only at edges where ce_1m=1.
  - Only entries already stored before that edge are eligible; a cpu_we or push in the same cycle is not eligible.
  - Priority: CPU pending first, unless starve counter == STARVE_LIM and the FIFO is non-empty; then the FIFO head is granted.
  - Starve counter increments on each CPU grant while the FIFO is non-empty; clears on a player grant or when the FIFO is empty.
- Issue:
  - The granted entry is registered onto sid_addr_w/sid_data; sid_we=1 for exactly the one clk after the grant edge.
  - The granted source is consumed: pending cleared, or FIFO popped.
  - If cpu_we coincides with the grant edge of the current CPU entry, the new write becomes the next pending entry; no overrun.
- Latency: cpu_we at cycle t, next eligible ce_1m at cycle t+k (k≥1) -> sid_we high in cycle t+k+1.
- sid_addr = sid_we ? registered write address : cpu_addr (combinational read path).
- Flush:
  - ply_en=0 sets read pointer = write pointer at the next edge; fifo_level reaches 0.
  - A grant taken at that same edge still issues.
- Full/empty:
  - Full: level = 2^FIFO_AW, ply_ready=0.
  - Empty: no player grant.
  - Pointers wrap modulo 2^FIFO_AW; level is width FIFO_AW+1.
- Push and pop on the same edge: level unchanged.

Optional Feature:
- Macro: SID_SHADOW_EN.
- Defined:
  - 25x8 shadow RAM records every issued write with addr ≤ 5'h18.
  - shadow_data = shadow[shadow_addr], registered, 1-cycle latency.
  - shadow_addr > 5'h18 returns 8'h00.
  - Used by the OSD/state-save path, because SID registers are write-only.
- Not defined: shadow_data tied to 8'h00; no RAM inferred.

Test Plan:
- CPU write 5'h18=8'h0F at cycle 3, ce_1m at cycle 10 -> sid_we high only in cycle 11 with addr 18/data 0F; pending cleared.
- Two cpu_we (04=41, then 04=40) before a ce_1m -> single issue of 04=40; cpu_overrun=1 until reset.
- FIFO_AW=2: push 5 entries with ply_valid held -> ply_ready drops after 4 accepts, fifo_level=4; four ce_1m slots drain them in order, level returns to 0.
- CPU pending every slot with FIFO non-empty, STARVE_LIM=8 -> 8 CPU issues, then 1 player issue, pattern repeats.
- ply_addr=5'h1B pushed -> level unchanged, no sid_we ever; ply_en=0 with level 3 -> level 0 next cycle, no player issues afterward.
- SID_SHADOW_EN: issue 01=1C, read shadow_addr=01 -> shadow_data=1C one cycle later; async reset mid-issue -> sid_we=0 immediately, shadow reads 00.
